// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read arbiter.
package axi_arb_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] k;

  // Scan upward from ptr, keeping the first hit.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt_idx = k;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between NUM_REQ requesters,
// one burst outstanding at a time, with burst-length checking.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]       s_arid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     s_araddr,
  input  logic [NUM_REQ-1:0][AXI_LEN_W-1:0]      s_arlen,
  input  logic [NUM_REQ-1:0][2:0]                s_arsize,
  input  logic [NUM_REQ-1:0][1:0]                s_arburst,
  input  logic [NUM_REQ-1:0]                     s_arlock,
  input  logic [NUM_REQ-1:0][3:0]                s_arcache,
  input  logic [NUM_REQ-1:0][2:0]                s_arprot,
  input  logic [NUM_REQ-1:0]                     s_arvalid,
  output logic [NUM_REQ-1:0]                     s_arready,
  output logic [NUM_REQ-1:0][ID_WIDTH-1:0]       s_rid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     s_rdata,
  output logic [NUM_REQ-1:0][1:0]                s_rresp,
  output logic [NUM_REQ-1:0]                     s_rlast,
  output logic [NUM_REQ-1:0]                     s_rvalid,
  input  logic [NUM_REQ-1:0]                     s_rready,
  output logic [ID_WIDTH-1:0]                    m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
  output logic [AXI_LEN_W-1:0]                   m_axi_arlen,
  output logic [2:0]                             m_axi_arsize,
  output logic [1:0]                             m_axi_arburst,
  output logic                                   m_axi_arlock,
  output logic [3:0]                             m_axi_arcache,
  output logic [2:0]                             m_axi_arprot,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  input  logic [ID_WIDTH-1:0]                    m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready,
  output logic [$clog2(NUM_REQ)-1:0]             grant,
  output logic                                   busy,
  output logic                                   len_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     ptr_inc;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [AXI_LEN_W-1:0] exp_len;
  logic [AXI_LEN_W-1:0] beat_cnt;
  logic                 ar_hs;
  logic                 r_hs;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (s_arvalid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // R payload is broadcast; only s_rvalid selects the owner.
  assign s_rid   = {NUM_REQ{m_axi_rid}};
  assign s_rdata = {NUM_REQ{m_axi_rdata}};
  assign s_rresp = {NUM_REQ{m_axi_rresp}};
  assign s_rlast = {NUM_REQ{m_axi_rlast}};

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign ar_hs   = (state_q == ADDR) && s_arvalid[grant_q] && m_axi_arready;
  assign r_hs    = (state_q == DATA) && m_axi_rvalid && s_rready[grant_q];
  assign ptr_inc = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus AR/R routing through the granted requester.
  always_comb begin
    state_d       = state_q;
    m_axi_arid    = '0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_arburst = '0;
    m_axi_arlock  = 1'b0;
    m_axi_arcache = '0;
    m_axi_arprot  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_arready     = '0;
    s_rvalid      = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = ADDR;
      end
      ADDR: begin
        m_axi_arid         = s_arid[grant_q];
        m_axi_araddr       = s_araddr[grant_q];
        m_axi_arlen        = s_arlen[grant_q];
        m_axi_arsize       = s_arsize[grant_q];
        m_axi_arburst      = s_arburst[grant_q];
        m_axi_arlock       = s_arlock[grant_q];
        m_axi_arcache      = s_arcache[grant_q];
        m_axi_arprot       = s_arprot[grant_q];
        m_axi_arvalid      = s_arvalid[grant_q];
        s_arready[grant_q] = m_axi_arready;
        if (!s_arvalid[grant_q]) state_d = IDLE;
        else if (m_axi_arready)  state_d = DATA;
      end
      DATA: begin
        s_rvalid[grant_q] = m_axi_rvalid;
        m_axi_rready      = s_rready[grant_q];
        if (r_hs && m_axi_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer, beat counting and sticky length error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q  <= '0;
      rr_ptr   <= '0;
      exp_len  <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && pick_any) grant_q <= pick_idx;
      if (ar_hs) begin
        exp_len  <= s_arlen[grant_q];
        beat_cnt <= '0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + AXI_LEN_W'(1);
        if (m_axi_rlast) begin
          if (beat_cnt != exp_len) len_err <= 1'b1;
          rr_ptr <= ptr_inc;
        end else if (beat_cnt == exp_len) begin
          len_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a table of bursts plus hand-written
// withdraw and mid-burst reset sequences, with an R-beat scoreboard.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned IDW = 13;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [N-1:0][IDW-1:0]     s_arid;
  logic [N-1:0][AW-1:0]      s_araddr;
  logic [N-1:0][7:0]         s_arlen;
  logic [N-1:0][2:0]         s_arsize;
  logic [N-1:0][1:0]         s_arburst;
  logic [N-1:0]              s_arlock;
  logic [N-1:0][3:0]         s_arcache;
  logic [N-1:0][2:0]         s_arprot;
  logic [N-1:0]              s_arvalid;
  logic [N-1:0]              s_arready;
  logic [N-1:0][IDW-1:0]     s_rid;
  logic [N-1:0][DW-1:0]      s_rdata;
  logic [N-1:0][1:0]         s_rresp;
  logic [N-1:0]              s_rlast;
  logic [N-1:0]              s_rvalid;
  logic [N-1:0]              s_rready;
  logic [IDW-1:0]            m_axi_arid;
  logic [AW-1:0]             m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arlock;
  logic [3:0]                m_axi_arcache;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [IDW-1:0]            m_axi_rid;
  logic [DW-1:0]             m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;
  logic [0:0]                grant;
  logic                      busy;
  logic                      len_err;

  axi_read_arbiter #(
    .NUM_REQ    (N),
    .ID_WIDTH   (IDW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_arid        (s_arid),
    .s_araddr      (s_araddr),
    .s_arlen       (s_arlen),
    .s_arsize      (s_arsize),
    .s_arburst     (s_arburst),
    .s_arlock      (s_arlock),
    .s_arcache     (s_arcache),
    .s_arprot      (s_arprot),
    .s_arvalid     (s_arvalid),
    .s_arready     (s_arready),
    .s_rid         (s_rid),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rlast       (s_rlast),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .grant         (grant),
    .busy          (busy),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;

  // One burst: who requests, what they ask for, how the slave behaves, what must result.
  typedef struct {
    logic [1:0]  mask;
    int unsigned len;
    int unsigned nb;
    int unsigned stall;
    bit          tog;
    int unsigned g;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  beat_t       sbq[$];
  vec_t        vt[10];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mkv(logic [1:0] m, int unsigned len, int unsigned nb,
                               int unsigned stall, bit tog, int unsigned g, logic err);
    vec_t v;
    v.mask = m; v.len = len; v.nb = nb; v.stall = stall; v.tog = tog; v.g = g; v.err = err;
    return v;
  endfunction

  task automatic clr_inputs();
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arlock = '0; s_arcache = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  // Starts at a negedge with the arbiter idle; ends at the negedge after rlast.
  task automatic run_burst(input int unsigned e, input vec_t v);
    int unsigned   cyc, acc, b;
    bit            have;
    logic [63:0]   addr;
    logic [IDW-1:0] id;
    beat_t         cur, expb;
    addr = 64'h1000 + 64'(e) * 64'h100 + 64'(v.g) * 64'h10;
    id   = IDW'(e * 16 + v.g);
    s_araddr[v.g]  = addr;
    s_arid[v.g]    = id;
    s_arlen[v.g]   = 8'(v.len);
    s_arsize[v.g]  = 3'd3;
    s_arburst[v.g] = BURST_INCR;
    s_arcache[v.g] = 4'h3;
    s_arvalid      = v.mask;
    m_axi_arready  = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); @(negedge clk); cyc++;
    end while (!m_axi_arvalid && cyc < 20);
    chk("ar_latency", 64'(cyc), 64'd1);
    chk("grant", 64'(grant), 64'(v.g));
    chk("m_araddr", m_axi_araddr, addr);
    chk("m_arid", 64'(m_axi_arid), 64'(id));
    chk("m_arlen", 64'(m_axi_arlen), 64'(v.len));
    chk("m_arsize", 64'(m_axi_arsize), 64'd3);
    chk("s_arready_low", 64'(s_arready), 64'd0);
    for (int unsigned i = 0; i < v.stall; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'hbad0_bad0_bad0_bad0;
      s_rready     = 2'b11;
      #1;
      chk("stall_araddr", m_axi_araddr, addr);
      chk("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("stall_rready", 64'(m_axi_rready), 64'd0);
      chk("stall_s_rvalid", 64'(s_rvalid), 64'd0);
      @(posedge clk); @(negedge clk);
    end
    m_axi_arready = 1'b1;
    #1;
    chk("s_arready", 64'(s_arready), 64'd1 << v.g);
    @(posedge clk); @(negedge clk);
    m_axi_arready   = 1'b0;
    s_arvalid[v.g]  = 1'b0;
    m_axi_rvalid    = 1'b0;
    #1;
    chk("ar_done", 64'(m_axi_arvalid), 64'd0);
    chk("data_s_arready", 64'(s_arready), 64'd0);
    chk("data_busy", 64'(busy), 64'd1);
    have = 1'b0; b = 0; acc = 0; cyc = 0;
    while (acc < v.nb && cyc < 400) begin
      if (!have) begin
        cur.d    = {$urandom, $urandom};
        cur.last = (b == v.nb - 1);
        sbq.push_back(cur);
        have = 1'b1;
        b++;
      end
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = cur.d;
      m_axi_rlast  = cur.last;
      m_axi_rid    = id;
      m_axi_rresp  = 2'b00;
      s_rready     = 2'b11;
      if (v.tog && (cyc % 2 == 1)) s_rready[v.g] = 1'b0;
      #1;
      chk("s_rvalid", 64'(s_rvalid), 64'd1 << v.g);
      chk("m_rready", 64'(m_axi_rready), 64'(s_rready[v.g]));
      if (s_rvalid[v.g] && s_rready[v.g]) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          expb = sbq.pop_front();
          chk("s_rdata", s_rdata[v.g], expb.d);
          chk("s_rlast", 64'(s_rlast[v.g]), 64'(expb.last));
          chk("s_rid", 64'(s_rid[v.g]), 64'(id));
        end
        acc++;
        have = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("beats_accepted", 64'(acc), 64'(v.nb));
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    sbq.delete();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    #1;
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_len_err", 64'(len_err), 64'(v.err));
    chk("end_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("end_arvalid", 64'(m_axi_arvalid), 64'd0);
  endtask

  initial begin
    int unsigned cyc;
    clr_inputs();
    // mask, len, beats, ar stall, rready toggle, expected grant, expected len_err
    vt[0] = mkv(2'b11,  7,  8, 0, 1'b0, 0, 1'b0);
    vt[1] = mkv(2'b11,  3,  4, 0, 1'b0, 1, 1'b0);
    vt[2] = mkv(2'b11,  0,  1, 0, 1'b0, 0, 1'b0);
    vt[3] = mkv(2'b11, 15, 16, 0, 1'b0, 1, 1'b0);
    vt[4] = mkv(2'b11,  7,  8, 5, 1'b1, 0, 1'b0);
    vt[5] = mkv(2'b11,  2,  3, 2, 1'b1, 1, 1'b0);
    vt[6] = mkv(2'b01,  7,  8, 0, 1'b0, 0, 1'b0);
    vt[7] = mkv(2'b01,  1,  2, 0, 1'b0, 0, 1'b0);
    vt[8] = mkv(2'b10,  7,  4, 0, 1'b0, 1, 1'b1);
    vt[9] = mkv(2'b01,  3,  4, 0, 1'b0, 0, 1'b1);

    // Reset state, with live-looking inputs that must not leak through.
    reset_n       = 1'b0;
    s_araddr[0]   = 64'hdead_beef;
    s_rready      = 2'b11;
    m_axi_rvalid  = 1'b1;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rready", 64'(m_axi_rready), 64'd0);
    chk("idle_araddr", m_axi_araddr, 64'd0);
    clr_inputs();

    for (int unsigned e = 0; e < 10; e++) run_burst(e, vt[e]);

    // Withdrawn arvalid in ADDR: back to IDLE, pointer untouched (still 1).
    s_arvalid    = 2'b10;
    s_araddr[1]  = 64'h3000;
    @(posedge clk); @(negedge clk);
    chk("wd_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("wd_grant", 64'(grant), 64'd1);
    s_arvalid = 2'b00;
    #1;
    chk("wd_arvalid_drop", 64'(m_axi_arvalid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("wd_idle", 64'(busy), 64'd0);
    run_burst(10, mkv(2'b11, 3, 4, 0, 1'b0, 1, 1'b1));
    run_burst(11, mkv(2'b01, 1, 2, 0, 1'b0, 0, 1'b1));

    // Reset during the third beat of a req1 burst (pointer is 1 beforehand).
    s_arvalid   = 2'b11;
    s_araddr[1] = 64'h2000;
    s_arlen[1]  = 8'd7;
    cyc = 0;
    do begin
      @(posedge clk); @(negedge clk); cyc++;
    end while (!m_axi_arvalid && cyc < 20);
    chk("mid_grant", 64'(grant), 64'd1);
    m_axi_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_axi_arready = 1'b0;
    s_arvalid     = 2'b00;
    s_rready      = 2'b11;
    m_axi_rvalid  = 1'b1;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = 64'h1234;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("mid_s_rvalid_pre", 64'(s_rvalid), 64'd2);
    chk("mid_busy_pre", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rready", 64'(m_axi_rready), 64'd0);
    chk("mid_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_len_err", 64'(len_err), 64'd0);
    chk("mid_grant_rst", 64'(grant), 64'd0);
    m_axi_rvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    // Pointer back at 0 picks req0; slave overruns past arlen before rlast.
    run_burst(12, mkv(2'b11, 7, 10, 0, 1'b0, 0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI4 read master port between `NUM_REQ` read requesters (icache fetch port at index 0, dcache fill port at index 1 by default). Grants are round-robin with exactly one burst outstanding at a time. Each granted burst holds the port from AR handshake through the `rlast` beat. A beat counter checks every burst's length against the granted `arlen` and flags mismatches.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..8)
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 64, AXI data width

Ports (`s_*` are packed arrays `[NUM_REQ-1:0]` of the listed width):
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `s_arid`, `s_araddr`, `s_arlen`, `s_arsize`, `s_arburst`, `s_arlock`, `s_arcache`, `s_arprot`  in  ID/ADDR/8/3/2/1/4/3  per-requester AR fields
- `s_arvalid`  in  1  per-requester AR valid
- `s_arready`  out  1  per-requester AR ready
- `s_rid`, `s_rdata`, `s_rresp`, `s_rlast`  out  ID/DATA/2/1  R fields, broadcast from master to all requesters
- `s_rvalid`  out  1  per-requester R valid, only the granted bit can be set
- `s_rready`  in  1  per-requester R ready
- `m_axi_ar*`  out  as AXI4  master AR channel (`arid`..`arprot`, `arvalid`)
- `m_axi_arready`  in  1
- `m_axi_rid`, `m_axi_rdata`, `m_axi_rresp`, `m_axi_rlast`, `m_axi_rvalid`  in  as AXI4
- `m_axi_rready`  out  1
- `grant`  out  $clog2(NUM_REQ)  index of current or last owner
- `busy`  out  1  state != IDLE
- `len_err`  out  1  sticky; set on a burst-length mismatch

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any `s_arvalid` is set, pick the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Register the pick in `grant` and go to ADDR.
- ADDR:
  - `m_axi_ar*` = `s_ar*[grant]`.
  - `m_axi_arvalid` = `s_arvalid[grant]`.
  - `s_arready[grant]` = `m_axi_arready`. All other `s_arready` are 0.
  - On handshake: latch `arlen` into `exp_len`, clear `beat_cnt`, go to DATA.
  - If `s_arvalid[grant]` drops before handshake (protocol violation), return to IDLE and leave `rr_ptr` unchanged.
- DATA:
  - `s_rvalid[grant]` = `m_axi_rvalid`.
  - `m_axi_rready` = `s_rready[grant]`.
  - On each R handshake, increment `beat_cnt` (8-bit).
  - On the `rlast` handshake:
    - If `beat_cnt != exp_len`, set `len_err`.
    - `rr_ptr` <= `grant`+1 modulo `NUM_REQ`.
    - Go to IDLE.
  - If `beat_cnt == exp_len` on a handshake without `rlast`, set `len_err`, keep routing, and wait for `rlast`.
- IDs pass through unchanged. A requester must not issue a new AR until its previous burst has completed.
- `len_err` clears only on reset.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant` 0, `busy` 0, `len_err` 0.
  - All `s_arready`, `s_rvalid`, `m_axi_arvalid`, `m_axi_rready` are 0.
  - `m_axi_ar*` fields are 0.
- Grant latency: `s_arvalid` sampled high in IDLE at edge N gives `m_axi_arvalid` high from cycle N+1.
- AR and R paths are combinational through the mux; there are no extra register stages.
- Between bursts: exactly one IDLE cycle after the `rlast` handshake.
  - Back-to-back bursts: rlast at N, IDLE at N+1, ADDR at N+2.
- A requester whose `s_arvalid` rises while another owns the port waits. No AR is accepted outside ADDR.
- Simultaneous requests in IDLE: round-robin order decides. With requesters i and j both waiting, each gets at most one burst before the other.
- An R beat arriving in IDLE or ADDR is not accepted, because `m_axi_rready` is 0.
- Reset asserted mid-burst: all outputs drop asynchronously to their reset values and the burst is abandoned. Upstream logic resets on the same signal.

## Structure
- Package `axi_arb_pkg`:
  - state enum `arb_state_t` (IDLE, ADDR, DATA)
  - AXI burst encodings (FIXED/INCR/WRAP)
  - `AXI_LEN_W`=8
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs `req[NUM_REQ]` and `ptr`; outputs `gnt_idx` and `any`.

## Test plan
- Single request: req0 AR at 0x1000 with arlen=7 → `m_axi_araddr`=0x1000 one cycle after arvalid, 8 beats routed to req0 only, `busy` drops the cycle after rlast, `len_err`=0.
- Simultaneous req0 and req1 from reset → req0 granted first, req1 granted at rlast+2, then req0 again when re-requesting; check that req0 and req1 alternate over 6 bursts.
- Backpressure: `m_axi_arready` low 5 cycles, `s_rready[grant]` toggled every other cycle → no beats lost or duplicated, AR fields stable while stalled.
- Length mismatch: arlen=7, slave asserts rlast on beat 4 → `len_err`=1 and stays set, arbiter returns to IDLE; also slave runs past beat 8 before rlast → `len_err`=1.
- Reset mid-burst: assert `reset_n`=0 during beat 3 → `m_axi_rready`, `s_rvalid`, `busy` are 0 immediately (before the next edge); after release, state is IDLE and `rr_ptr`=0.
- Arvalid withdrawn in ADDR → return to IDLE, same requester re-granted on its next request.
